// File: rtl/ship_missile.sv
// ship_missile: single player missile launched from the ship nose on a fresh
// fire-key press. It climbs once per frame and retires at the top of the play
// field or on a hit, then waits out a fixed re-arm cooldown.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no missile; waiting for ship armed and a fresh fire press
// FLIGHT   | missile visible, climbing MISSILE_Y_Step pixels per frame
// COOLDOWN | missile retired; counting down before re-arm
module ship_missile #(
  parameter logic [9:0] X_Offset        = 10'd7,
  parameter logic [9:0] Y_Launch_Offset = 10'd8,
  parameter logic [9:0] MISSILE_Y_Step  = 10'd4,
  parameter logic [9:0] MISSILE_Y_Min   = 10'd8,
  parameter logic [3:0] COOLDOWN_FRAMES = 4'd8,
  parameter logic [7:0] FIRE_KEY        = 8'h2C
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  input  logic [9:0]  SHIPX,
  input  logic [9:0]  SHIPY,
  input  logic        ship,
  input  logic        hit,
  output logic [9:0]  MISSILEX,
  output logic [9:0]  MISSILEY,
  output logic        missile,
  output logic [7:0]  shot_count
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FLIGHT   = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  // Retire once the next step would cross the top boundary; comparing against
  // the sum keeps MISSILEY from ever wrapping below zero.
  localparam logic [9:0] Y_RETIRE = MISSILE_Y_Min + MISSILE_Y_Step;
  localparam logic [3:0] CD_LOAD  = COOLDOWN_FRAMES - 4'd1;

  logic [1:0] state_q, state_d;
  logic [9:0] mx_q, mx_d;
  logic [9:0] my_q, my_d;
  logic       missile_q, missile_d;
  logic [7:0] count_q, count_d;
  logic [3:0] cd_q, cd_d;
  logic       fire_prev_q;
  logic       fire_key;
  logic       fire_edge;

  assign fire_key  = (keycode[7:0] == FIRE_KEY) | (keycode[15:8] == FIRE_KEY);
  assign fire_edge = fire_key & ~fire_prev_q;

  // Next-state and datapath decisions for the missile FSM.
  always_comb begin
    state_d   = state_q;
    mx_d      = mx_q;
    my_d      = my_q;
    missile_d = missile_q;
    count_d   = count_q;
    cd_d      = cd_q;
    case (state_q)
      IDLE: begin
        if (ship && fire_edge) begin
          mx_d      = SHIPX + X_Offset;
          my_d      = SHIPY - Y_Launch_Offset;
          missile_d = 1'b1;
          count_d   = count_q + 8'd1;
          state_d   = FLIGHT;
        end
      end
      FLIGHT: begin
        if (!ship) begin
          // Disarm skips the cooldown so a re-armed ship can fire at once.
          missile_d = 1'b0;
          state_d   = IDLE;
        end else if (hit || (my_q < Y_RETIRE)) begin
          missile_d = 1'b0;
          cd_d      = CD_LOAD;
          state_d   = COOLDOWN;
        end else begin
          my_d = my_q - MISSILE_Y_Step;
        end
      end
      COOLDOWN: begin
        if (!ship || (cd_q == 4'd0)) begin
          state_d = IDLE;
        end else begin
          cd_d = cd_q - 4'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        missile_d = 1'b0;
      end
    endcase
  end

  // State registers; fire_prev tracks the key in every state so presses
  // landing in FLIGHT or COOLDOWN are consumed rather than deferred.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      mx_q        <= 10'd0;
      my_q        <= 10'd0;
      missile_q   <= 1'b0;
      count_q     <= 8'd0;
      cd_q        <= 4'd0;
      fire_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mx_q        <= mx_d;
      my_q        <= my_d;
      missile_q   <= missile_d;
      count_q     <= count_d;
      cd_q        <= cd_d;
      fire_prev_q <= fire_key;
    end
  end

  assign MISSILEX   = mx_q;
  assign MISSILEY   = my_q;
  assign missile    = missile_q;
  assign shot_count = count_q;

endmodule

// File: tb/tb_ship_missile.sv
// Directed bench for ship_missile: a vector table for launch and early
// flight, then hand-written sequences for boundary, cooldown, hit, disarm,
// async reset, held key and shot counter wrap.
module tb_ship_missile;

  logic        frame_clk;
  logic        Reset;
  logic [15:0] keycode;
  logic [9:0]  SHIPX;
  logic [9:0]  SHIPY;
  logic        ship;
  logic        hit;
  logic [9:0]  MISSILEX;
  logic [9:0]  MISSILEY;
  logic        missile;
  logic [7:0]  shot_count;

  int checks;
  int errors;

  ship_missile dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .SHIPX      (SHIPX),
    .SHIPY      (SHIPY),
    .ship       (ship),
    .hit        (hit),
    .MISSILEX   (MISSILEX),
    .MISSILEY   (MISSILEY),
    .missile    (missile),
    .shot_count (shot_count)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic        ship;
    logic [15:0] key;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        hit;
    logic        em;
    logic [9:0]  ex;
    logic [9:0]  ey;
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs[6];

  task automatic apply(input logic s, input logic [15:0] k, input logic [9:0] x,
                       input logic [9:0] y, input logic h);
    ship    = s;
    keycode = k;
    SHIPX   = x;
    SHIPY   = y;
    hit     = h;
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check(input string name, input logic em, input logic [9:0] ex,
                       input logic [9:0] ey, input logic [7:0] ec);
    checks++;
    if ({missile, MISSILEX, MISSILEY, shot_count} !== {em, ex, ey, ec}) begin
      errors++;
      $display("FAIL %s: got missile=%0b X=%0d Y=%0d cnt=%0d, want missile=%0b X=%0d Y=%0d cnt=%0d",
               name, missile, MISSILEX, MISSILEY, shot_count, em, ex, ey, ec);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // ship, key, SHIPX, SHIPY, hit -> missile, X, Y, count
    vecs[0] = '{1'b0, 16'h002C, 10'd100, 10'd250, 1'b0, 1'b0, 10'd0,   10'd0,   8'd0};
    vecs[1] = '{1'b1, 16'h0000, 10'd100, 10'd250, 1'b0, 1'b0, 10'd0,   10'd0,   8'd0};
    vecs[2] = '{1'b1, 16'h002C, 10'd100, 10'd250, 1'b0, 1'b1, 10'd107, 10'd242, 8'd1};
    vecs[3] = '{1'b1, 16'h0000, 10'd100, 10'd250, 1'b0, 1'b1, 10'd107, 10'd238, 8'd1};
    vecs[4] = '{1'b1, 16'h002C, 10'd300, 10'd250, 1'b0, 1'b1, 10'd107, 10'd234, 8'd1};
    vecs[5] = '{1'b1, 16'h0000, 10'd300, 10'd250, 1'b0, 1'b1, 10'd107, 10'd230, 8'd1};

    Reset = 1'b1;
    apply(1'b0, 16'h0000, 10'd0, 10'd0, 1'b0);
    #3;
    check("reset", 1'b0, 10'd0, 10'd0, 8'd0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      apply(vecs[i].ship, vecs[i].key, vecs[i].sx, vecs[i].sy, vecs[i].hit);
      tick();
      check($sformatf("vec%0d", i), vecs[i].em, vecs[i].ex, vecs[i].ey, vecs[i].ec);
    end

    // Climb to the boundary: Y = 242 - 4k up to k = 58 (Y = 10).
    for (int k = 4; k <= 58; k++) begin
      tick();
      check($sformatf("flight_k%0d", k), 1'b1, 10'd107, 10'(242 - 4 * k), 8'd1);
    end
    tick();
    check("boundary_retire", 1'b0, 10'd107, 10'd10, 8'd1);

    // Cooldown edges 1..7 idle key, press on edge 8 must be lost.
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("cooldown_e%0d", e), 1'b0, 10'd107, 10'd10, 8'd1);
    end
    apply(1'b1, 16'h002C, 10'd300, 10'd250, 1'b0);
    tick();
    check("cooldown_last_press_lost", 1'b0, 10'd107, 10'd10, 8'd1);
    apply(1'b1, 16'h0000, 10'd300, 10'd250, 1'b0);
    tick();
    check("idle_after_cooldown", 1'b0, 10'd107, 10'd10, 8'd1);
    apply(1'b1, 16'h002C, 10'd50, 10'd208, 1'b0);
    tick();
    check("relaunch", 1'b1, 10'd57, 10'd200, 8'd2);

    // Hit at Y=200, then a lost press mid-cooldown, then relaunch at R+9.
    apply(1'b1, 16'h0000, 10'd50, 10'd208, 1'b1);
    tick();
    check("hit_retire", 1'b0, 10'd57, 10'd200, 8'd2);
    for (int e = 1; e <= 8; e++) begin
      if (e == 2) keycode = 16'h002C;
      else keycode = 16'h0000;
      tick();
      check($sformatf("hit_cooldown_e%0d", e), 1'b0, 10'd57, 10'd200, 8'd2);
    end
    apply(1'b1, 16'h002C, 10'd50, 10'd208, 1'b0);
    tick();
    check("post_hit_relaunch", 1'b1, 10'd57, 10'd200, 8'd3);

    // Disarm mid-flight, then immediate relaunch without cooldown.
    apply(1'b0, 16'h0000, 10'd50, 10'd208, 1'b0);
    tick();
    check("disarm", 1'b0, 10'd57, 10'd200, 8'd3);
    apply(1'b1, 16'h002C, 10'd50, 10'd208, 1'b0);
    tick();
    check("rearm_launch", 1'b1, 10'd57, 10'd200, 8'd4);
    tick();
    check("held_no_refire", 1'b1, 10'd57, 10'd196, 8'd4);

    // Async reset between edges, with the fire key held across release.
    #2;
    keycode = 16'h2C00;
    Reset = 1'b1;
    #1;
    check("async_reset", 1'b0, 10'd0, 10'd0, 8'd0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    check("reset_held", 1'b0, 10'd0, 10'd0, 8'd0);
    apply(1'b1, 16'h2C00, 10'd100, 10'd30, 1'b0);
    tick();
    check("held_key_fresh_after_reset", 1'b1, 10'd107, 10'd22, 8'd1);
    for (int j = 0; j < 3; j++) tick();
    check("held_short_flight", 1'b1, 10'd107, 10'd10, 8'd1);
    tick();
    check("held_retire", 1'b0, 10'd107, 10'd10, 8'd1);
    for (int j = 0; j < 26; j++) tick();
    check("held_single_launch", 1'b0, 10'd107, 10'd10, 8'd1);
    keycode = 16'h0000;
    tick();
    keycode = 16'h2C00;
    tick();
    check("held_repress", 1'b1, 10'd107, 10'd22, 8'd2);

    // 256 launches from reset; counter reads 255 then wraps to 0.
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      apply(1'b0, 16'h0000, 10'd20, 10'd40, 1'b0);
      tick();
      apply(1'b1, 16'h002C, 10'd20, 10'd40, 1'b0);
      tick();
      if (n == 255) check("count_255", 1'b1, 10'd27, 10'd32, 8'd255);
      if (n == 256) check("count_wrap", 1'b1, 10'd27, 10'd32, 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ship_missile.md
# ship_missile

Player-missile controller that sits directly downstream of the ship block. It consumes the ship's position and armed flag plus the raw keycode, launches a single missile from the ship's nose on a fresh fire-key press, and moves it upward once per frame. The missile retires at the top boundary or on a hit from the collision logic, followed by a fixed re-arm cooldown. Its outputs feed the sprite/colour mapper and the enemy collision checker.

## Interface

- X_Offset, 10'd7: added to SHIPX to give the missile X at launch (ship nose centre for a 16-px sprite).
- Y_Launch_Offset, 10'd8: subtracted from SHIPY to give the missile Y at launch.
- MISSILE_Y_Step, 10'd4: upward pixels per frame.
- MISSILE_Y_Min, 10'd8: top boundary of the play field.
- COOLDOWN_FRAMES, 4'd8: frames spent in COOLDOWN after a missile retires; range 1–15.
- FIRE_KEY, 8'h2C: fire keycode (space).

- frame_clk  in  1  frame clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- keycode  in  16  two key slots, [7:0] and [15:8].
- SHIPX  in  10  ship X position.
- SHIPY  in  10  ship Y position.
- ship  in  1  ship armed/alive; 1 = game running.
- hit  in  1  collision logic reports that the missile struck an enemy; level, sampled each frame.
- MISSILEX  out  10  missile X; constant during flight.
- MISSILEY  out  10  missile Y.
- missile  out  1  missile active/visible.
- shot_count  out  8  launches since reset; wraps from 255 to 0.

## Operation

- fire_key = (keycode[7:0]==FIRE_KEY) | (keycode[15:8]==FIRE_KEY). fire_prev is a register updated with fire_key on every frame edge in every state. fire_edge = fire_key & ~fire_prev.
- States are IDLE, FLIGHT and COOLDOWN. The cooldown counter is 4 bits wide.
- Reset: state=IDLE, MISSILEX=0, MISSILEY=0, missile=0, shot_count=0, fire_prev=0, cooldown counter=0.
- IDLE:
  - If ship & fire_edge: MISSILEX<=SHIPX+X_Offset, MISSILEY<=SHIPY-Y_Launch_Offset, missile<=1, shot_count<=shot_count+1, go to FLIGHT.
  - Otherwise hold all outputs.
- FLIGHT, evaluated in priority order:
  1. ~ship: missile<=0, go to IDLE (no cooldown).
  2. hit: missile<=0, load counter with COOLDOWN_FRAMES-1, go to COOLDOWN.
  3. MISSILEY < MISSILE_Y_Min+MISSILE_Y_Step: missile<=0, load counter, go to COOLDOWN.
  4. Otherwise MISSILEY<=MISSILEY-MISSILE_Y_Step.
  - fire_edge is ignored in FLIGHT.
- COOLDOWN:
  - If ~ship: go to IDLE.
  - Else if counter==0: go to IDLE.
  - Else decrement the counter.
  - hit and fire_edge are ignored.
- MISSILEX and MISSILEY hold their last values whenever missile=0.
- Arithmetic is unsigned 10-bit. The boundary test uses the sum MISSILE_Y_Min+MISSILE_Y_Step, so MISSILEY never underflows.
- At most one missile exists at a time.
- A fire press that lands in FLIGHT or COOLDOWN is lost. The key must be released and pressed again.

## Timing

- Launch takes effect on the same frame edge at which fire_edge and ship are sampled high. It uses the SHIPX value present before that edge, i.e. the ship's pre-update position.
- Movement: one step per frame, starting at the edge after launch.
- Retire: missile drops to 0 on the edge at which hit, the boundary condition or ~ship is sampled.
- COOLDOWN lasts exactly COOLDOWN_FRAMES edges, followed by one IDLE edge. The earliest relaunch is therefore COOLDOWN_FRAMES+1 edges after the retire edge.
- Reset mid-flight forces the reset values immediately (asynchronously) and clears fire_prev. A key still held as reset deasserts then counts as a fresh edge.
- If hit and the boundary condition occur on the same edge, hit has priority; the result is identical (COOLDOWN).

## Test plan

- Basic launch: Reset, then ship=1, SHIPX=100, SHIPY=250, press keycode=16'h002C for 1 frame -> after that edge missile=1, MISSILEX=107, MISSILEY=242, shot_count=1.
- Flight and boundary: continue from the basic launch with no hit -> MISSILEY=242-4k after k frames, reaching 10 at k=58. missile falls to 0 at k=59. It stays 0 for 8 COOLDOWN edges, plus 1 IDLE edge, before a relaunch is accepted.
- Held key: hold 16'h2C00 through launch, flight and cooldown -> exactly one launch and shot_count=1. Release, then press again in IDLE -> second launch, shot_count=2.
- Hit: launch, then assert hit at MISSILEY=200 -> missile=0 on that edge, MISSILEY holds 200, COOLDOWN entered. A fire press during cooldown produces no launch.
- Disarm and gating: fire with ship=0 -> no launch. Launch with ship=1, then drop ship mid-flight -> missile=0 and state IDLE next edge. Re-arm and press fire -> immediate launch with no cooldown.
- Async reset and wrap: assert Reset mid-flight between clock edges -> missile, MISSILEX, MISSILEY and shot_count read 0 before the next edge. Perform 256 launches -> shot_count wraps to 0.
